// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice.
//   state_t      : sequencer states (2-bit encoding)
//   DIGIT_W      : width of each BCD digit output
//   MIN_MAX_DEF  : default highest minute count
//   SEC_MAX_DEF  : default highest second count
package stopwatch_pkg;

    localparam int DIGIT_W     = 5;
    localparam int MIN_MAX_DEF = 99;
    localparam int SEC_MAX_DEF = 59;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_ADJUST = 2'd3
    } state_t;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that wraps from MAX back to 00.
//   clk   in  : rising-edge clock
//   rst   in  : synchronous active-high reset (value -> 00)
//   clr   in  : synchronous clear (value -> 00), overrides inc
//   inc   in  : advance by one
//   tens  out : registered tens digit
//   units out : registered units digit
//   carry out : combinational, high when inc=1 and the value is MAX
module bcd2_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = SEC_MAX_DEF,
    parameter int DW  = DIGIT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [DW-1:0] tens,
    output logic [DW-1:0] units,
    output logic          carry
);

    localparam logic [DW-1:0] MAX_T = DW'(MAX / 10);
    localparam logic [DW-1:0] MAX_U = DW'(MAX % 10);
    localparam logic [DW-1:0] ONE   = DW'(1);
    localparam logic [DW-1:0] NINE  = DW'(9);

    logic [DW-1:0] r_tens;
    logic [DW-1:0] r_units;
    logic          w_at_max;

    assign w_at_max = (r_tens == MAX_T) && (r_units == MAX_U);
    assign carry    = inc && w_at_max;
    assign tens     = r_tens;
    assign units    = r_units;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_tens  <= '0;
            r_units <= '0;
        end else if (inc) begin
            if (w_at_max) begin
                r_tens  <= '0;
                r_units <= '0;
            end else if (r_units == NINE) begin
                r_units <= '0;
                r_tens  <= r_tens + ONE;
            end else begin
                r_units <= r_units + ONE;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/adjust sequencer and MM:SS BCD count datapath.
//   clk, rst            : clock and synchronous active-high reset
//   tick_1hz, tick_2hz  : pre-divided 1-cycle strobes (count / adjust+blink)
//   pause_p, clear_p    : debounced 1-cycle button pulses
//   adj, sel            : adjust-mode level and field select (0=min, 1=sec)
//   min_l/min_r/sec_l/sec_r : registered BCD digits to the display
//   running, adj_active : registered state flags
//   blink_on            : registered display enable for the selected field
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DW      = DIGIT_W,
    parameter int MIN_MAX = MIN_MAX_DEF,
    parameter int SEC_MAX = SEC_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_1hz,
    input  logic          tick_2hz,
    input  logic          pause_p,
    input  logic          clear_p,
    input  logic          adj,
    input  logic          sel,
    output logic [DW-1:0] min_l,
    output logic [DW-1:0] min_r,
    output logic [DW-1:0] sec_l,
    output logic [DW-1:0] sec_r,
    output logic          running,
    output logic          adj_active,
    output logic          blink_on
);

    state_t r_state;
    state_t w_next;
    logic   r_running;
    logic   r_adj_active;
    logic   r_blink;

    logic   w_sec_inc;
    logic   w_min_inc;
    logic   w_sec_carry;
    logic   w_min_carry_unused;
    logic   w_adj_tick;

    assign w_adj_tick = (r_state == ST_ADJUST) && tick_2hz;
    assign w_sec_inc  = ((r_state == ST_RUN) && tick_1hz) || (w_adj_tick && sel);
    // Seconds carry only reaches minutes while running; adjust edits fields independently.
    assign w_min_inc  = ((r_state == ST_RUN) && w_sec_carry) || (w_adj_tick && !sel);

    bcd2_counter #(.MAX(SEC_MAX), .DW(DW)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear_p),
        .inc   (w_sec_inc),
        .tens  (sec_l),
        .units (sec_r),
        .carry (w_sec_carry)
    );

    bcd2_counter #(.MAX(MIN_MAX), .DW(DW)) u_min (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear_p),
        .inc   (w_min_inc),
        .tens  (min_l),
        .units (min_r),
        .carry (w_min_carry_unused)
    );

    always_comb begin
        w_next = r_state;
        if (clear_p) begin
            w_next = adj ? ST_ADJUST : ST_IDLE;
        end else if (adj) begin
            w_next = ST_ADJUST;
        end else if (r_state == ST_ADJUST) begin
            w_next = ST_PAUSE;
        end else if (pause_p) begin
            unique case (r_state)
                ST_IDLE:  w_next = ST_RUN;
                ST_RUN:   w_next = ST_PAUSE;
                ST_PAUSE: w_next = ST_RUN;
                default:  w_next = r_state;
            endcase
        end
    end

    // Flags are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_running    <= 1'b0;
            r_adj_active <= 1'b0;
            r_blink      <= 1'b1;
        end else begin
            r_state      <= w_next;
            r_running    <= (w_next == ST_RUN);
            r_adj_active <= (w_next == ST_ADJUST);
            if ((r_state == ST_ADJUST) && (w_next == ST_ADJUST)) begin
                if (tick_2hz) begin
                    r_blink <= ~r_blink;
                end
            end else begin
                r_blink <= 1'b1;
            end
        end
    end

    assign running    = r_running;
    assign adj_active = r_adj_active;
    assign blink_on   = r_blink;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl: directed scenarios plus randomized stimulus
// checked against a total-seconds behavioural model.
module tb_stopwatch_ctrl;

    localparam int MINM = 99;
    localparam int SECM = 59;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_ADJ   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       tick_2hz = 1'b0;
    logic       pause_p = 1'b0;
    logic       clear_p = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [4:0] min_l, min_r, sec_l, sec_r;
    logic       running, adj_active, blink_on;

    int checks = 0;
    int failures = 0;

    int m_min = 0;
    int m_sec = 0;
    int m_state = S_IDLE;
    bit m_blink = 1'b1;

    stopwatch_ctrl #(.DW(5), .MIN_MAX(MINM), .SEC_MAX(SECM)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .tick_2hz   (tick_2hz),
        .pause_p    (pause_p),
        .clear_p    (clear_p),
        .adj        (adj),
        .sel        (sel),
        .min_l      (min_l),
        .min_r      (min_r),
        .sec_l      (sec_l),
        .sec_r      (sec_r),
        .running    (running),
        .adj_active (adj_active),
        .blink_on   (blink_on)
    );

    always #5 clk = ~clk;

    // DUT display as MMSS decimal; X digits propagate to an X result.
    function automatic logic [31:0] dut_mmss();
        return ((32'(min_l) * 10 + 32'(min_r)) * 100) + 32'(sec_l) * 10 + 32'(sec_r);
    endfunction

    // Reference model: the count is a single number of seconds.
    task automatic model_step();
        int tot;
        int nxt;
        if (rst) begin
            m_min = 0; m_sec = 0; m_state = S_IDLE; m_blink = 1'b1;
            return;
        end
        if (clear_p) begin
            m_min = 0; m_sec = 0;
        end else if (m_state == S_RUN && tick_1hz) begin
            tot = (m_min * (SECM + 1) + m_sec + 1) % ((MINM + 1) * (SECM + 1));
            m_min = tot / (SECM + 1);
            m_sec = tot % (SECM + 1);
        end else if (m_state == S_ADJ && tick_2hz) begin
            if (sel) m_sec = (m_sec + 1) % (SECM + 1);
            else     m_min = (m_min + 1) % (MINM + 1);
        end
        if (clear_p)               nxt = adj ? S_ADJ : S_IDLE;
        else if (adj)              nxt = S_ADJ;
        else if (m_state == S_ADJ) nxt = S_PAUSE;
        else if (pause_p)          nxt = (m_state == S_RUN) ? S_PAUSE : S_RUN;
        else                       nxt = m_state;
        if (m_state == S_ADJ && nxt == S_ADJ) begin
            if (tick_2hz) m_blink = !m_blink;
        end else begin
            m_blink = 1'b1;
        end
        m_state = nxt;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulse(input bit t1, input bit t2, input bit p, input bit c);
        tick_1hz = t1; tick_2hz = t2; pause_p = p; clear_p = c;
        cycle();
        tick_1hz = 1'b0; tick_2hz = 1'b0; pause_p = 1'b0; clear_p = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pulse(1'b1, 1'b0, 1'b0, 1'b0);
            pulse(1'b0, 1'b1, 1'b0, 1'b0);
            cycle();
        end
        checks++;
        if (dut_mmss() !== 32'd0) begin
            failures++; $display("FAIL reset_digits got=%0d exp=0", dut_mmss());
        end
        checks++;
        if (running !== 1'b0 || adj_active !== 1'b0) begin
            failures++; $display("FAIL reset_flags running=%b adj_active=%b exp=0,0", running, adj_active);
        end
        checks++;
        if (blink_on !== 1'b1) begin
            failures++; $display("FAIL reset_blink got=%b exp=1", blink_on);
        end
    endtask

    task automatic test_run_count();
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 61; i++) begin
            pulse(1'b1, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        checks++;
        if (dut_mmss() !== 32'd101 || running !== 1'b1) begin
            failures++; $display("FAIL run61 got=%0d running=%b exp=101 running=1", dut_mmss(), running);
        end
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (running !== 1'b0) begin
            failures++; $display("FAIL pause_flag got=%b exp=0", running);
        end
        for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut_mmss() !== 32'd101) begin
            failures++; $display("FAIL paused_hold got=%0d exp=101", dut_mmss());
        end
    endtask

    task automatic test_wrap();
        adj = 1'b1;
        cycle();
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        sel = 1'b0;
        for (int i = 0; i < MINM; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        sel = 1'b1;
        for (int i = 0; i < SECM; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (dut_mmss() !== 32'd9959) begin
            failures++; $display("FAIL preload got=%0d exp=9959", dut_mmss());
        end
        adj = 1'b0;
        cycle();
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut_mmss() !== 32'd0 || running !== 1'b1) begin
            failures++; $display("FAIL full_wrap got=%0d running=%b exp=0 running=1", dut_mmss(), running);
        end
    endtask

    task automatic test_adjust_seconds();
        bit exp_b [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 58; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        adj = 1'b1; sel = 1'b1;
        cycle();
        checks++;
        if (adj_active !== 1'b1 || blink_on !== 1'b1 || dut_mmss() !== 32'd58) begin
            failures++; $display("FAIL adj_entry adj_active=%b blink=%b count=%0d exp=1,1,58", adj_active, blink_on, dut_mmss());
        end
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, 1'b1, 1'b0, 1'b0);
            checks++;
            if (blink_on !== exp_b[i]) begin
                failures++; $display("FAIL blink_seq step=%0d got=%b exp=%b", i, blink_on, exp_b[i]);
            end
        end
        checks++;
        if (dut_mmss() !== 32'd1) begin
            failures++; $display("FAIL adj_sec_wrap got=%0d exp=1", dut_mmss());
        end
        adj = 1'b0;
        cycle();
        checks++;
        if (adj_active !== 1'b0 || running !== 1'b0 || blink_on !== 1'b1) begin
            failures++; $display("FAIL adj_exit adj_active=%b running=%b blink=%b exp=0,0,1", adj_active, running, blink_on);
        end
    endtask

    task automatic test_pause_same_cycle();
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut_mmss() !== 32'd9 || running !== 1'b1) begin
            failures++; $display("FAIL pre_same got=%0d running=%b exp=9 running=1", dut_mmss(), running);
        end
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (dut_mmss() !== 32'd10 || running !== 1'b0) begin
            failures++; $display("FAIL tick_and_pause got=%0d running=%b exp=10 running=0", dut_mmss(), running);
        end
    endtask

    task automatic test_clear_adj();
        adj = 1'b1;
        cycle();
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        sel = 1'b0;
        for (int i = 0; i < 12; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        sel = 1'b1;
        for (int i = 0; i < 34; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (dut_mmss() !== 32'd1234) begin
            failures++; $display("FAIL adj_preset got=%0d exp=1234", dut_mmss());
        end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (dut_mmss() !== 32'd0 || adj_active !== 1'b1) begin
            failures++; $display("FAIL clear_with_adj got=%0d adj_active=%b exp=0,1", dut_mmss(), adj_active);
        end
        adj = 1'b0;
        cycle();
    endtask

    task automatic test_rst_midcarry();
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 59; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut_mmss() !== 32'd59) begin
            failures++; $display("FAIL pre_rst got=%0d exp=59", dut_mmss());
        end
        rst = 1'b1;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checks++;
        if (dut_mmss() !== 32'd0 || running !== 1'b0 || adj_active !== 1'b0 || blink_on !== 1'b1) begin
            failures++; $display("FAIL rst_midcarry got=%0d running=%b adj=%b blink=%b exp=0,0,0,1", dut_mmss(), running, adj_active, blink_on);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut_mmss() !== 32'd0) begin
            failures++; $display("FAIL idle_after_rst got=%0d exp=0", dut_mmss());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(499) == 0);
            tick_1hz = ($urandom_range(2) == 0);
            tick_2hz = ($urandom_range(3) == 0);
            pause_p  = ($urandom_range(15) == 0);
            clear_p  = ($urandom_range(99) == 0);
            if ($urandom_range(59) == 0) adj = ~adj;
            sel      = $urandom_range(1);
            cycle();
            checks++;
            if (dut_mmss() !== 32'(m_min * 100 + m_sec)) begin
                failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", i, dut_mmss(), m_min * 100 + m_sec);
            end
            checks++;
            if (running !== (m_state == S_RUN) || adj_active !== (m_state == S_ADJ)) begin
                failures++; $display("FAIL rand_state cyc=%0d running=%b adj_active=%b exp_state=%0d", i, running, adj_active, m_state);
            end
            checks++;
            if (blink_on !== m_blink) begin
                failures++; $display("FAIL rand_blink cyc=%0d got=%b exp=%b", i, blink_on, m_blink);
            end
        end
        rst = 1'b0; tick_1hz = 1'b0; tick_2hz = 1'b0; pause_p = 1'b0; clear_p = 1'b0; adj = 1'b0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_run_count();
        test_wrap();
        test_adjust_seconds();
        test_pause_same_cycle();
        test_clear_adj();
        test_rst_midcarry();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
